// File: rtl/axi_rd_wishbone_bridge.sv
`default_nettype none
// =============================================================================
// Module   : axi_rd_wishbone_bridge
// Function : AXI4 read-only slave to Wishbone classic master; each burst beat
//            becomes one single-word Wishbone read cycle.
// Option   : BRIDGE_PREFETCH_EN adds a 2-entry read-data FIFO so WB fetches
//            run ahead of the AXI R handshake.
// Revision : 1.0 - initial release
// =============================================================================
module axi_rd_wishbone_bridge #(
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                axi_arvalid_i,
  input  logic [31:0]         axi_araddr_i,
  input  logic [ID_WIDTH-1:0] axi_arid_i,
  input  logic [7:0]          axi_arlen_i,
  output logic                axi_arready_o,
  output logic                axi_rvalid_o,
  output logic [31:0]         axi_rdata_o,
  output logic [1:0]          axi_rresp_o,
  output logic [ID_WIDTH-1:0] axi_rid_o,
  output logic                axi_rlast_o,
  input  logic                axi_rready_i,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [31:0]         wb_addr_o,
  input  logic [31:0]         wb_data_i,
  input  logic                wb_ack_i
);

  localparam logic [1:0]  C_RESP_OKAY   = 2'b00;
  localparam logic [1:0]  C_RESP_SLVERR = 2'b10;
  localparam logic [31:0] C_WORD_MASK   = 32'hFFFF_FFFC;
  localparam logic [31:0] C_TIMEOUT     = TIMEOUT_CYCLES;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                arready_q, arready_d;
  logic                cyc_q, cyc_d;
  logic [31:0]         addr_q, addr_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          beat_q, beat_d;
  logic [31:0]         tmo_q, tmo_d;

  logic                w_tmo_hit;
  logic                w_beat_done;
  logic                w_beat_last;
  logic [31:0]         w_beat_data;
  logic [1:0]          w_beat_resp;

  // A beat completes either by ack or by the wait counter reaching its limit.
  assign w_tmo_hit   = (C_TIMEOUT != 32'd0) && !wb_ack_i && ((tmo_q + 32'd1) == C_TIMEOUT);
  assign w_beat_done = cyc_q && (wb_ack_i || w_tmo_hit);
  assign w_beat_data = wb_ack_i ? wb_data_i : 32'd0;
  assign w_beat_resp = wb_ack_i ? C_RESP_OKAY : C_RESP_SLVERR;
  assign w_beat_last = (beat_q == len_q);

  assign axi_arready_o = arready_q;
  assign axi_rid_o     = id_q;
  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = cyc_q;
  assign wb_we_o       = 1'b0;
  assign wb_addr_o     = addr_q;

`ifndef BRIDGE_PREFETCH_EN
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rlast_q, rlast_d;

  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    cyc_d     = cyc_q;
    addr_d    = addr_q;
    id_d      = id_q;
    len_d     = len_q;
    beat_d    = beat_q;
    tmo_d     = tmo_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    unique case (state_q)
      S_IDLE: begin
        arready_d = 1'b1;
        if (axi_arvalid_i && arready_q) begin
          addr_d    = axi_araddr_i & C_WORD_MASK;
          id_d      = axi_arid_i;
          len_d     = axi_arlen_i;
          beat_d    = 8'd0;
          tmo_d     = 32'd0;
          arready_d = 1'b0;
          cyc_d     = 1'b1;
          state_d   = S_BUS;
        end
      end
      S_BUS: begin
        if (w_beat_done) begin
          cyc_d    = 1'b0;
          rvalid_d = 1'b1;
          rdata_d  = w_beat_data;
          rresp_d  = w_beat_resp;
          rlast_d  = w_beat_last;
          state_d  = S_RESP;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      S_RESP: begin
        if (axi_rready_i) begin
          rvalid_d = 1'b0;
          if (rlast_q) begin
            arready_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            addr_d  = addr_q + 32'd4;
            beat_d  = beat_q + 8'd1;
            tmo_d   = 32'd0;
            cyc_d   = 1'b1;
            state_d = S_BUS;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      rresp_q  <= 2'b00;
      rlast_q  <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rlast_q  <= rlast_d;
    end
  end

  assign axi_rvalid_o = rvalid_q;
  assign axi_rdata_o  = rdata_q;
  assign axi_rresp_o  = rresp_q;
  assign axi_rlast_o  = rlast_q;
`else
  // Entry layout: {rresp[1:0], rlast, rdata[31:0]}
  logic [34:0] fifo_q [2];
  logic [34:0] fifo_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        w_push;
  logic        w_pop;

  assign w_pop = (cnt_q != 2'd0) && axi_rready_i;

  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    cyc_d     = cyc_q;
    addr_d    = addr_q;
    id_d      = id_q;
    len_d     = len_q;
    beat_d    = beat_q;
    tmo_d     = tmo_q;
    fifo_d[0] = fifo_q[0];
    fifo_d[1] = fifo_q[1];
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    w_push    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        arready_d = 1'b1;
        if (axi_arvalid_i && arready_q) begin
          addr_d    = axi_araddr_i & C_WORD_MASK;
          id_d      = axi_arid_i;
          len_d     = axi_arlen_i;
          beat_d    = 8'd0;
          tmo_d     = 32'd0;
          arready_d = 1'b0;
          cyc_d     = 1'b1;
          state_d   = S_BUS;
        end
      end
      S_BUS: begin
        if (cyc_q) begin
          if (w_beat_done) begin
            cyc_d  = 1'b0;
            w_push = 1'b1;
            if (w_beat_last) begin
              state_d = S_RESP;
            end else begin
              addr_d = addr_q + 32'd4;
              beat_d = beat_q + 8'd1;
            end
          end else begin
            tmo_d = tmo_q + 32'd1;
          end
        end else if ((cnt_q != 2'd2) || w_pop) begin
          // Restart fetching only when a FIFO slot is guaranteed free.
          cyc_d = 1'b1;
          tmo_d = 32'd0;
        end
      end
      S_RESP: begin
        if ((cnt_q == 2'd1) && w_pop) begin
          arready_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (w_push) begin
      fifo_d[wr_ptr_q] = {w_beat_resp, w_beat_last, w_beat_data};
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (w_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, w_push} - {1'b0, w_pop};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      fifo_q[0] <= fifo_d[0];
      fifo_q[1] <= fifo_d[1];
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign axi_rvalid_o = (cnt_q != 2'd0);
  assign axi_rdata_o  = fifo_q[rd_ptr_q][31:0];
  assign axi_rlast_o  = fifo_q[rd_ptr_q][32];
  assign axi_rresp_o  = fifo_q[rd_ptr_q][34:33];
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      arready_q <= 1'b0;
      cyc_q     <= 1'b0;
      addr_q    <= 32'd0;
      id_q      <= '0;
      len_q     <= 8'd0;
      beat_q    <= 8'd0;
      tmo_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      cyc_q     <= cyc_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      tmo_q     <= tmo_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_wishbone_bridge.sv
`default_nettype none
// =============================================================================
// Module   : tb_axi_rd_wishbone_bridge
// Function : Self-checking bench for axi_rd_wishbone_bridge (table of bursts
//            with a Wishbone slave model and an expected-beat scoreboard).
// Revision : 1.0 - initial release
// =============================================================================
module tb_axi_rd_wishbone_bridge;

  localparam int C_TMO = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        axi_arvalid_i;
  logic [31:0] axi_araddr_i;
  logic [3:0]  axi_arid_i;
  logic [7:0]  axi_arlen_i;
  logic        axi_arready_o;
  logic        axi_rvalid_o;
  logic [31:0] axi_rdata_o;
  logic [1:0]  axi_rresp_o;
  logic [3:0]  axi_rid_o;
  logic        axi_rlast_o;
  logic        axi_rready_i;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;

  axi_rd_wishbone_bridge #(
    .ID_WIDTH       (4),
    .TIMEOUT_CYCLES (C_TMO)
  ) u_dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .axi_arvalid_i (axi_arvalid_i),
    .axi_araddr_i  (axi_araddr_i),
    .axi_arid_i    (axi_arid_i),
    .axi_arlen_i   (axi_arlen_i),
    .axi_arready_o (axi_arready_o),
    .axi_rvalid_o  (axi_rvalid_o),
    .axi_rdata_o   (axi_rdata_o),
    .axi_rresp_o   (axi_rresp_o),
    .axi_rid_o     (axi_rid_o),
    .axi_rlast_o   (axi_rlast_o),
    .axi_rready_i  (axi_rready_i),
    .wb_cyc_o      (wb_cyc_o),
    .wb_stb_o      (wb_stb_o),
    .wb_we_o       (wb_we_o),
    .wb_addr_o     (wb_addr_o),
    .wb_data_i     (wb_data_i),
    .wb_ack_i      (wb_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    int          ack_delay;
    bit          noack;
    bit          spurious;
    int          stall_beat;
    int          stall_cycles;
    int          rst_beat;
  } vec_t;

  localparam int NV = 8;
  vec_t        vecs [NV];
  beat_t       exp_q [$];
  logic [31:0] wb_addr_exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [31:0] pat(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic vec_t mk(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                              input int dly, input bit noack, input bit spur,
                              input int sb, input int sc, input int rb);
    vec_t v;
    v.addr = addr; v.id = id; v.len = len; v.ack_delay = dly; v.noack = noack;
    v.spurious = spur; v.stall_beat = sb; v.stall_cycles = sc; v.rst_beat = rb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_arready", 32'(axi_arready_o), 32'd0);
    check("rst_rvalid",  32'(axi_rvalid_o),  32'd0);
    check("rst_rlast",   32'(axi_rlast_o),   32'd0);
    check("rst_cyc",     32'(wb_cyc_o),      32'd0);
    check("rst_stb",     32'(wb_stb_o),      32'd0);
    check("rst_we",      32'(wb_we_o),       32'd0);
    check("rst_rdata",   axi_rdata_o,        32'd0);
    check("rst_rresp",   32'(axi_rresp_o),   32'd0);
    check("rst_rid",     32'(axi_rid_o),     32'd0);
    check("rst_addr",    wb_addr_o,          32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] a;
    beat_t       b;
    beat_t       e;
    logic [31:0] st_data;
    logic [31:0] ea;
    int          beats, cyc_cnt, stall_left, budget, started;
    bit          prev_cyc, ar_fire, st_valid, aborted;

    exp_q.delete();
    wb_addr_exp_q.delete();
    a = v.addr & 32'hFFFF_FFFC;
    for (int i = 0; i <= int'(v.len); i++) begin
      wb_addr_exp_q.push_back(a);
      b.data = v.noack ? 32'd0 : pat(a);
      b.resp = v.noack ? 2'b10 : 2'b00;
      b.last = (i == int'(v.len));
      b.id   = v.id;
      exp_q.push_back(b);
      a = a + 32'd4;
    end

    axi_arvalid_i = 1'b1;
    axi_araddr_i  = v.addr;
    axi_arid_i    = v.id;
    axi_arlen_i   = v.len;
    beats = 0; cyc_cnt = 0; stall_left = v.stall_cycles; budget = 3000; started = 0;
    prev_cyc = 1'b0; ar_fire = 1'b0; st_valid = 1'b0; aborted = 1'b0; st_data = 32'd0;

    while ((beats <= int'(v.len)) && (budget > 0) && !aborted) begin
      if (ar_fire) axi_arvalid_i = 1'b0;
      if (axi_arvalid_i && axi_arready_o) ar_fire = 1'b1;

      if ((v.rst_beat >= 0) && (beats == v.rst_beat) && wb_cyc_o && prev_cyc) begin
        rst_i        = 1'b1;
        wb_ack_i     = 1'b0;
        axi_rready_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        check_reset_outputs();
        @(negedge clk_i);
        check("post_rst_arready", 32'(axi_arready_o), 32'd1);
        aborted = 1'b1;
      end else begin
        // Wishbone slave model
        if (wb_cyc_o) begin
          if (!prev_cyc) begin
            started++;
            if (wb_addr_exp_q.size() == 0) begin
              check("wb_extra_cycle", wb_addr_o, 32'hFFFF_FFFF);
            end else begin
              ea = wb_addr_exp_q.pop_front();
              check("wb_addr", wb_addr_o, ea);
            end
            check("wb_stb", 32'(wb_stb_o), 32'd1);
            check("wb_we",  32'(wb_we_o),  32'd0);
            cyc_cnt = 0;
          end
          cyc_cnt++;
          wb_ack_i  = !v.noack && (cyc_cnt > v.ack_delay);
          wb_data_i = pat(wb_addr_o);
        end else begin
          if (prev_cyc && v.noack) check("timeout_cycles", 32'(cyc_cnt), 32'(C_TMO));
          wb_ack_i  = v.spurious;
          wb_data_i = 32'hBAD0_BAD0;
        end
        prev_cyc = wb_cyc_o;

        // AXI R consumer with optional back-pressure
        if (axi_rvalid_o && (beats == v.stall_beat) && (stall_left > 0)) begin
          axi_rready_i = 1'b0;
          if (st_valid) check("stall_rdata_stable", axi_rdata_o, st_data);
`ifndef BRIDGE_PREFETCH_EN
          check("stall_no_wb", 32'(wb_cyc_o), 32'd0);
`else
          check("stall_prefetch_depth", 32'((started - beats) <= 3), 32'd1);
`endif
          st_data  = axi_rdata_o;
          st_valid = 1'b1;
          stall_left--;
        end else begin
          axi_rready_i = 1'b1;
          if (axi_rvalid_o) begin
            if (exp_q.size() == 0) begin
              check("r_extra_beat", axi_rdata_o, 32'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              check("rdata", axi_rdata_o,        e.data);
              check("rresp", 32'(axi_rresp_o),   32'(e.resp));
              check("rlast", 32'(axi_rlast_o),   32'(e.last));
              check("rid",   32'(axi_rid_o),     32'(e.id));
            end
            beats++;
            st_valid = 1'b0;
          end
        end
        @(negedge clk_i);
        budget--;
      end
    end

    axi_rready_i  = 1'b0;
    wb_ack_i      = 1'b0;
    axi_arvalid_i = 1'b0;
    if (budget == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL burst_budget: burst at 0x%08h got %0d beats, expected %0d", v.addr, beats, int'(v.len) + 1);
    end else if (!aborted) begin
      check("end_arready", 32'(axi_arready_o), 32'd1);
      check("end_no_cyc",  32'(wb_cyc_o),      32'd0);
      @(negedge clk_i);
    end
  endtask

  initial begin
    vecs[0] = mk(32'h0000_0100, 4'd0, 8'd0, 1, 1'b0, 1'b0, -1, 0, -1);
    vecs[1] = mk(32'h0000_0200, 4'd5, 8'd3, 0, 1'b0, 1'b0, -1, 0, -1);
    vecs[2] = mk(32'h0000_0300, 4'd3, 8'd3, 2, 1'b0, 1'b0,  2, 10, -1);
    vecs[3] = mk(32'h0000_0400, 4'd7, 8'd2, 0, 1'b1, 1'b0, -1, 0, -1);
    vecs[4] = mk(32'hFFFF_FFFC, 4'd9, 8'd1, 0, 1'b0, 1'b0, -1, 0, -1);
    vecs[5] = mk(32'h0000_1003, 4'd1, 8'd2, 1, 1'b0, 1'b1, -1, 0, -1);
    vecs[6] = mk(32'h0000_0500, 4'd2, 8'd7, 1, 1'b0, 1'b0, -1, 0,  1);
    vecs[7] = mk(32'h0000_0600, 4'hF, 8'd0, 0, 1'b0, 1'b0, -1, 0, -1);

    rst_i         = 1'b1;
    axi_arvalid_i = 1'b0;
    axi_araddr_i  = 32'd0;
    axi_arid_i    = 4'd0;
    axi_arlen_i   = 8'd0;
    axi_rready_i  = 1'b0;
    wb_data_i     = 32'd0;
    wb_ack_i      = 1'b0;
    repeat (3) @(negedge clk_i);
    check_reset_outputs();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("idle_arready", 32'(axi_arready_o), 32'd1);

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
